// File: rtl/ram_arbiter_if.sv
// Master-side bus bundle for one port of the two-master RAM arbiter.
// Carries the request/command toward the arbiter and the grant/read return back.
interface ram_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          req;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          grant;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (
        output req, wr, addr, wdata,
        input  grant, rvalid, rdata
    );

    modport slave (
        input  req, wr, addr, wdata,
        output grant, rvalid, rdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and sequencer putting two masters onto one single-port RAM.
// A master keeps the RAM for at most BURST beats while the other one waits,
// and read data returned by the RAM one cycle later is steered to its issuer.
module ram_arbiter #(
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int BURST = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    ram_arbiter_if.slave  m0,
    ram_arbiter_if.slave  m1,
    output logic          ram_cen,
    output logic          ram_wen,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    localparam int            CW   = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CW-1:0] CMAX = CW'(BURST - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          last;
    logic          last_next;
    logic          rd_pend;
    logic          rd_owner;

    logic          grant0;
    logic          grant1;
    logic          beat0;
    logic          beat1;
    logic          rvalid0;
    logic          rvalid1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;

    // State register with beat counter and round-robin memory; last=1 lets M0 win the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= 1'b1;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            last  <= last_next;
        end
    end

    // Next-state: keep the owner while it requests unless the other waits and the cap is hit.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        last_next  = last;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (m0.req && m1.req) begin
                    state_next = last ? GRANT0 : GRANT1;
                end else if (m0.req) begin
                    state_next = GRANT0;
                end else if (m1.req) begin
                    state_next = GRANT1;
                end
            end
            GRANT0: begin
                if (m0.req && (!m1.req || cnt < CMAX)) begin
                    cnt_next = (cnt == CMAX) ? cnt : cnt + CW'(1);
                end else begin
                    cnt_next   = '0;
                    last_next  = 1'b0;
                    state_next = m1.req ? GRANT1 : IDLE;
                end
            end
            GRANT1: begin
                if (m1.req && (!m0.req || cnt < CMAX)) begin
                    cnt_next = (cnt == CMAX) ? cnt : cnt + CW'(1);
                end else begin
                    cnt_next   = '0;
                    last_next  = 1'b1;
                    state_next = m0.req ? GRANT0 : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs: Moore grants, RAM command only during a beat, read data gated by its valid.
    always_comb begin
        grant0   = (state == GRANT0);
        grant1   = (state == GRANT1);
        beat0    = grant0 & m0.req;
        beat1    = grant1 & m1.req;
        ram_cen  = 1'b0;
        ram_wen  = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (beat0) begin
            ram_cen  = 1'b1;
            ram_wen  = m0.wr;
            ram_addr = m0.addr;
            ram_din  = m0.wdata;
        end else if (beat1) begin
            ram_cen  = 1'b1;
            ram_wen  = m1.wr;
            ram_addr = m1.addr;
            ram_din  = m1.wdata;
        end
        rvalid0 = rd_pend & ~rd_owner;
        rvalid1 = rd_pend & rd_owner;
        rdata0  = rvalid0 ? ram_dout : '0;
        rdata1  = rvalid1 ? ram_dout : '0;
    end

    // Remember which master issued a read beat so the next cycle's RAM data goes to it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            rd_pend  <= (beat0 & ~m0.wr) | (beat1 & ~m1.wr);
            rd_owner <= beat1;
        end
    end

    assign m0.grant  = grant0;
    assign m1.grant  = grant1;
    assign m0.rvalid = rvalid0;
    assign m1.rvalid = rvalid1;
    assign m0.rdata  = rdata0;
    assign m1.rdata  = rdata1;

endmodule
